ftoi: RTL and testbench

Pipelined IEEE-754 single-precision to signed 32-bit integer converter, the inverse of the FPU's `itof` unit. It sits in the FPU alongside `itof` and feeds the integer register writeback path. The converter rounds to nearest with ties away from zero. It has a fixed two-cycle latency, a valid tag that travels with the data, and a global stall that freezes the whole pipe.

---
 rtl/ftoi.sv | 112 +++++++++++
 tb/tb_ftoi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ftoi.sv
`default_nettype none
// ============================================================================
// Module   : ftoi
// Purpose  : Two-stage IEEE-754 single to signed int32 converter.
//            Rounding is round-half-away-from-zero.
//            Define FTOI_SATURATE_EN for saturating overflow.
//            Without it, all overflow, Inf and NaN inputs give 0x80000000.
// Revision : 1.0 - initial release
// ============================================================================
module ftoi (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        in_valid,
  input  logic        stall,
  output logic [31:0] y,
  output logic        out_valid
);

  logic        x_sign;
  logic [7:0]  x_exp;
  logic [23:0] x_sig;
  logic [7:0]  rsh;
  logic [7:0]  lsh;
  logic [24:0] rshifted;
  logic [31:0] lshifted;
  logic [31:0] mag_c;
  logic        rnd_c;
  logic        ovf_c;

  logic        s1_sign;
  logic        s1_ovf;
  logic [31:0] s1_mag;
  logic        s1_rnd;
  logic        s1_valid;

  logic [31:0] mag_rnd;
  logic [31:0] ovf_val;
  logic [31:0] y_c;

  assign x_sign = x[31];
  assign x_exp  = x[30:23];
  assign x_sig  = {1'b1, x[22:0]};

  // The extra LSB of rshifted captures the round bit just below the integer part.
  assign rsh      = 8'd150 - x_exp;
  assign lsh      = x_exp - 8'd150;
  assign rshifted = {x_sig, 1'b0} >> rsh;
  assign lshifted = {8'd0, x_sig} << lsh;

  always_comb begin
    mag_c = 32'd0;
    rnd_c = 1'b0;
    ovf_c = 1'b0;
    if (x_exp < 8'd126) begin
      mag_c = 32'd0;
    end else if (x_exp <= 8'd149) begin
      mag_c = {8'd0, rshifted[24:1]};
      rnd_c = rshifted[0];
    end else if (x_exp <= 8'd157) begin
      mag_c = lshifted;
    end else if (x_sign && (x_exp == 8'd158) && (x[22:0] == 23'd0)) begin
      mag_c = 32'h8000_0000;
    end else begin
      ovf_c = 1'b1;
    end
  end

`ifdef FTOI_SATURATE_EN
  logic nan_c;
  logic s1_nan;

  assign nan_c   = (x_exp == 8'hFF) && (x[22:0] != 23'd0);
  assign ovf_val = (s1_nan || !s1_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_nan <= 1'b0;
    end else if (!stall) begin
      s1_nan <= nan_c;
    end
  end
`else
  assign ovf_val = 32'h8000_0000;
`endif

  // Magnitude is below 2^24 whenever the round bit can be set, so no carry-out.
  assign mag_rnd = s1_mag + {31'd0, s1_rnd};
  assign y_c     = s1_ovf ? ovf_val : (s1_sign ? (32'd0 - mag_rnd) : mag_rnd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_sign   <= 1'b0;
      s1_ovf    <= 1'b0;
      s1_mag    <= 32'd0;
      s1_rnd    <= 1'b0;
      s1_valid  <= 1'b0;
      y         <= 32'd0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_sign   <= x_sign;
      s1_ovf    <= ovf_c;
      s1_mag    <= mag_c;
      s1_rnd    <= rnd_c;
      s1_valid  <= in_valid;
      y         <= y_c;
      out_valid <= s1_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ftoi.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftoi
// Purpose  : Self-checking bench for ftoi: directed table, random stream,
//            stall and mid-stream reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftoi;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic        in_valid;
  logic        stall;
  logic [31:0] y;
  logic        out_valid;

  int checks;
  int errors;

  ftoi dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .in_valid  (in_valid),
    .stall     (stall),
    .y         (y),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scale by 2^24, add one half, truncate.
  function automatic logic [31:0] ref_ftoi(input logic [31:0] v);
    logic        s;
    int          e;
    logic [63:0] sc;
    logic [31:0] mag;
    s = v[31];
    e = int'(v[30:23]);
    if (e >= 158) begin
      if (e == 158 && s && v[22:0] == 23'd0) return 32'h8000_0000;
`ifdef FTOI_SATURATE_EN
      if (e == 255 && v[22:0] != 23'd0) return 32'h7FFF_FFFF;
      return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      return 32'h8000_0000;
`endif
    end
    if (e < 126) begin
      mag = 32'd0;
    end else begin
      sc  = {40'd0, 1'b1, v[22:0]} << (e - 126);
      mag = 32'((sc + 64'h80_0000) >> 24);
    end
    return s ? (32'd0 - mag) : mag;
  endfunction

  vec_t        tbl[12];
  logic [31:0] rx[50];
  logic [31:0] ry[50];
  logic [31:0] held;

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    x        = 32'd0;
    in_valid = 1'b0;
    stall    = 1'b0;

    tbl[0]  = '{"r1p5",    32'h3FC0_0000, 32'h0000_0002};
    tbl[1]  = '{"rm1p5",   32'hBFC0_0000, 32'hFFFF_FFFE};
    tbl[2]  = '{"r2p5",    32'h4020_0000, 32'h0000_0003};
    tbl[3]  = '{"r0p5",    32'h3F00_0000, 32'h0000_0001};
    tbl[4]  = '{"rbelow",  32'h3EFF_FFFF, 32'h0000_0000};
    tbl[5]  = '{"negzero", 32'h8000_0000, 32'h0000_0000};
    tbl[6]  = '{"max24",   32'h4B7F_FFFF, 32'h00FF_FFFF};
    tbl[7]  = '{"maxexp",  32'h4EFF_FFFF, 32'h7FFF_FF80};
    tbl[8]  = '{"min32",   32'hCF00_0000, 32'h8000_0000};
`ifdef FTOI_SATURATE_EN
    tbl[9]  = '{"ovfpos",  32'h4F00_0000, 32'h7FFF_FFFF};
    tbl[10] = '{"neginf",  32'hFF80_0000, 32'h8000_0000};
    tbl[11] = '{"nan",     32'h7FC0_0000, 32'h7FFF_FFFF};
`else
    tbl[9]  = '{"ovfpos",  32'h4F00_0000, 32'h8000_0000};
    tbl[10] = '{"neginf",  32'hFF80_0000, 32'h8000_0000};
    tbl[11] = '{"nan",     32'h7FC0_0000, 32'h8000_0000};
`endif

    // Reset state
    step();
    step();
    check("reset_y", y, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    rstn = 1'b1;
    step();

    // Directed table, one input per cycle, each result two cycles later
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) begin
        x        = tbl[i].x;
        in_valid = 1'b1;
      end else begin
        x        = 32'd0;
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        check({tbl[i-1].name, "_y"}, y, tbl[i-1].y);
        check({tbl[i-1].name, "_v"}, {31'd0, out_valid}, 32'd1);
      end
    end
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Random back-to-back stream
    for (int i = 0; i < 50; i++) begin
      rx[i] = $urandom;
      if (i % 2 == 0) rx[i][30:23] = 8'(120 + $urandom_range(0, 37));
      ry[i] = ref_ftoi(rx[i]);
    end
    for (int i = 0; i <= 50; i++) begin
      if (i < 50) begin
        x        = rx[i];
        in_valid = 1'b1;
      end else begin
        x        = 32'd0;
        in_valid = 1'b0;
      end
      step();
      if (i == 0) check("stream_first_v", {31'd0, out_valid}, 32'd0);
      if (i >= 1) begin
        check($sformatf("stream%0d_v", i - 1), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream%0d_y x=%08h", i - 1, rx[i-1]), y, ry[i-1]);
      end
    end
    step();

    // Stall with two requests in flight
    x = 32'h4120_0000; in_valid = 1'b1;   // 10.0
    step();
    x = 32'hC0E0_0000; in_valid = 1'b1;   // -7.0
    step();
    check("stall_a_y", y, 32'h0000_000A);
    stall = 1'b1;
    x     = 32'h4040_0000;                // 3.0, must be dropped
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_hold%0d_y", k), y, 32'h0000_000A);
      check($sformatf("stall_hold%0d_v", k), {31'd0, out_valid}, 32'd1);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    x        = 32'd0;
    step();
    check("stall_b_y", y, 32'hFFFF_FFF9);
    check("stall_b_v", {31'd0, out_valid}, 32'd1);
    step();
    check("stall_drop_v", {31'd0, out_valid}, 32'd0);
    step();

    // Reset asserted asynchronously with requests in flight
    x = 32'h4120_0000; in_valid = 1'b1;
    step();
    x = 32'h4140_0000; in_valid = 1'b1;   // 12.0
    step();
    held = y;
    check("prereset_y", held, 32'h0000_000A);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_y", y, 32'd0);
    check("async_rst_v", {31'd0, out_valid}, 32'd0);
    step();
    step();
    #2;
    rstn = 1'b1;
    @(negedge clk);
    x = 32'h4120_0000; in_valid = 1'b1;
    step();
    check("postrst_stale_v", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    x        = 32'd0;
    step();
    check("postrst_y", y, 32'h0000_000A);
    check("postrst_v", {31'd0, out_valid}, 32'd1);
    step();
    check("postrst_end_v", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
